// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive word addresses, keeping a running XOR checksum.
module instr_mem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_num_words;
    logic [7:0]  r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic [31:0] r_checksum;
    logic        r_err;

    logic        w_start_ok;
    logic        w_too_many;
    logic        w_hs;
    logic        w_last_byte;
    logic        w_last_word;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_too_many  = {24'd0, num_words} > DEPTH_U;
    assign w_hs        = byte_valid && (r_state == S_LOAD);
    assign w_last_byte = w_hs && (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_idx + 8'd1) == r_num_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = ADDR_BASE;
        mem_wdata  = 32'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    // Empty or oversized requests finish immediately without writing.
                    if ((num_words == 8'd0) || w_too_many) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = r_word;
                mem_addr  = ADDR_BASE + {22'd0, r_word_idx, 2'b00};
                w_next    = w_last_word ? S_DONE : S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_words <= 8'd0;
            r_word_idx  <= 8'd0;
            r_byte_cnt  <= 2'd0;
            r_word      <= 32'd0;
            r_checksum  <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_num_words <= num_words;
                r_word_idx  <= 8'd0;
                r_byte_cnt  <= 2'd0;
                r_word      <= 32'd0;
                r_checksum  <= 32'd0;
                r_err       <= w_too_many;
            end
            // Byte counter wraps to 0 on the 4th byte, ready for the next word.
            if (w_hs) begin
                r_word[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
                r_byte_cnt                        <= r_byte_cnt + 2'd1;
            end
            if (r_state == S_WRITE) begin
                r_checksum <= r_checksum ^ r_word;
                r_word_idx <= r_word_idx + 8'd1;
            end
        end
    end

    assign err      = r_err;
    assign checksum = r_checksum;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL provide parameter DEPTH, default 64, maximum number of 32-bit words loadable per session.
REQ-002 SHALL provide parameter ADDR_BASE, default 32'h0, byte address of the first word written.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a load session; sampled in IDLE or DONE only.
REQ-007 num_words  input  8  words to load; sampled on the cycle start is accepted.
REQ-008 byte_in  input  8  program byte stream.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 mem_addr  output  32  byte address of the word being written.
REQ-013 mem_wdata  output  32  assembled instruction word.
REQ-014 busy  output  1  session in progress; holds the CPU fetch stage.
REQ-015 done  output  1  session finished; level in DONE.
REQ-016 err  output  1  last session rejected (num_words > DEPTH).
REQ-017 checksum  output  32  XOR of all words written in the current or last session.

Function
REQ-018 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-019 IDLE/DONE + start=1: num_words=0 -> DONE with no writes; num_words>DEPTH -> DONE with err=1 and no writes; otherwise -> LOAD with word counter, byte counter, checksum and err cleared.
REQ-020 start in LOAD or WRITE SHALL be ignored.
REQ-021 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid && byte_ready.
REQ-022 Bytes SHALL be packed little-endian: 1st accepted byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-023 On acceptance of the 4th byte, the state SHALL move to WRITE on the next edge; no byte is accepted in WRITE.
REQ-024 In WRITE, mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = ADDR_BASE + 4*word_index; checksum updates with the word on that edge.
REQ-025 After WRITE, the word index increments; if it equals num_words -> DONE, else -> LOAD with byte counter 0.
REQ-026 Latency: mem_we asserts the cycle after the 4th byte handshake; minimum 5 cycles per word with byte_valid held at 1.
REQ-027 byte_valid low in LOAD SHALL stall without losing partially assembled bytes.
REQ-028 mem_addr arithmetic SHALL be 32-bit modulo 2^32; num_words is unsigned.
REQ-029 mem_we=0, mem_wdata=0 and mem_addr=ADDR_BASE outside WRITE.
REQ-030 busy=1 in LOAD and WRITE only; done=1 in DONE only; err and checksum hold until the next accepted start.

Reset
REQ-031 rst_n=0 SHALL force, asynchronously, state IDLE, byte_ready=0, mem_we=0, mem_addr=ADDR_BASE, mem_wdata=0, busy=0, done=0, err=0, checksum=0, and clear all counters.
REQ-032 Reset mid-session SHALL discard any partial word; already-written words are not rewritten; next session starts from word 0.

Verification
REQ-033 start, num_words=1, bytes 14,00,A0,E3 back-to-back -> one mem_we, mem_addr=0, mem_wdata=E3A00014, checksum=E3A00014, done=1, busy=0.
REQ-034 num_words=2, words E3A00014 then E3A01A01, byte_valid toggled every other cycle -> writes at 0 and 4, no lost bytes, checksum=00001A15.
REQ-035 start with num_words=0 -> DONE next cycle, no mem_we, err=0; num_words=65 (DEPTH=64) -> DONE, err=1, no mem_we.
REQ-036 rst_n pulsed low after 2 bytes of word 1 of 3 -> all outputs at reset values immediately; new session writes its first word at address 0.
REQ-037 start asserted during LOAD/WRITE -> ignored; session completes with original num_words and addresses.
REQ-038 DEPTH=64 full load of 64 words -> last write at mem_addr=0xFC, exactly 64 mem_we pulses, done=1.
